fetch_unit: RTL

Instruction fetch stage of the single-cycle RISC-V core. Holds the program counter and requests instruction words from instruction memory over a ready handshake. Presents the fetched word to decode, which includes `imm_gen` and the control unit. Computes the next PC from the decoded immediate (`imm_out`) when the consumer acknowledges an instruction with a redirect.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/pc_next_calc.sv | 16 +
 rtl/fetch_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential step or PC-relative redirect, with alignment flag.
module pc_next_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        redirect,
  output logic [31:0] target,
  output logic        misaligned
);

  // 32-bit modulo add; carry out is intentionally dropped.
  assign target     = redirect ? (pc + imm) : (pc + PC_STEP);
  assign misaligned = |target[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem ready handshake, hold-until-ack, redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        instr_ack,
  input  logic        redirect,
  input  logic [31:0] imm,
  output logic        misalign_err,
  output logic [31:0] instret
);

  fetch_state_e state, state_nxt;
  logic [31:0]  target;
  logic         misaligned;
  logic         fetch_done;
  logic         retire;

  pc_next_calc u_pc_next (
    .pc         (pc),
    .imm        (imm),
    .redirect   (redirect),
    .target     (target),
    .misaligned (misaligned)
  );

  assign fetch_done = (state == S_FETCH) && imem_ready;
  assign retire     = (state == S_HOLD) && instr_ack;

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = S_HOLD;
      end
      S_HOLD:  if (instr_ack) state_nxt = misaligned ? S_ERR : S_FETCH;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      instret      <= '0;
    end else begin
      state <= state_nxt;
      if (fetch_done) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (retire) begin
        instret     <= instret + 32'd1;
        instr_valid <= 1'b0;
        // A misaligned target leaves pc pointing at the offending instruction.
        if (misaligned) misalign_err <= 1'b1;
        else            pc           <= target;
      end
    end
  end

endmodule
